// File: rtl/game_pkg.sv
// Shared cat/dog/chicken codes, round FSM states and
// the win/scenario helpers used by the game-logic stage.
package game_pkg;

  localparam logic [2:0] CAT     = 3'b001;
  localparam logic [2:0] DOG     = 3'b010;
  localparam logic [2:0] CHICKEN = 3'b100;

  typedef enum logic [2:0] {
    P1_WAIT,
    P2_WAIT,
    RESOLVE,
    SHOW,
    SCORE,
    OVER
  } state_t;

  function automatic logic is_animal(
    input logic [2:0] c
  );
    return (c == CAT) || (c == DOG) ||
           (c == CHICKEN);
  endfunction

  function automatic logic [1:0] code(
    input logic [2:0] c
  );
    logic [1:0] r;
    r = 2'd2;
    unique case (1'b1)
      c[0]:    r = 2'd0;
      c[1]:    r = 2'd1;
      default: r = 2'd2;
    endcase
    return r;
  endfunction

  function automatic logic beats(
    input logic [2:0] a,
    input logic [2:0] b
  );
    return (a == DOG && b == CAT) ||
           (a == CAT && b == CHICKEN) ||
           (a == CHICKEN && b == DOG);
  endfunction

  // cat/cat lands on bit 8, chicken/chicken on bit 0
  function automatic logic [8:0] scenario_bit(
    input logic [2:0] p1,
    input logic [2:0] p2
  );
    logic [3:0] idx;
    logic [8:0] top;
    idx = {2'b00, code(p1)} * 4'd3 +
          {2'b00, code(p2)};
    top = 9'b1_0000_0000;
    return top >> idx;
  endfunction

endpackage

// File: rtl/key_press_edge.sv
// Two-flop synchronizer plus registered rising-edge detect;
// a key already high when clear releases never fires.
module key_press_edge (
  input  logic clk,
  input  logic i_clr,
  input  logic i_key,
  output logic o_press
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_press;
  logic [2:0] r_vld;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_prev  <= 1'b0;
      r_press <= 1'b0;
      r_vld   <= 3'b000;
    end else begin
      r_s1    <= i_key;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_vld   <= {r_vld[1:0], 1'b1};
      // only compare once r_prev holds a real sample
      r_press <= r_s2 & ~r_prev & r_vld[2];
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/round_judge.sv
// One round of cat/dog/chicken: latch both players, show the
// scenario until drawn, then score and detect match end.
module round_judge
  import game_pkg::*;
#(
  parameter int WIN_SCORE = 5
) (
  input  logic       clk,
  input  logic       stateReset,
  input  logic [2:0] choice,
  input  logic       userCont,
  input  logic       draw_done,
  output logic [8:0] scenario,
  output logic       scenario_valid,
  output logic       winner1,
  output logic       winner2,
  output logic [3:0] player1,
  output logic [3:0] player2,
  output logic [1:0] phase,
  output logic       bad_choice
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_p1;
  logic [2:0] r_p2;
  logic [8:0] r_scen;
  logic       r_w1;
  logic       r_w2;
  logic [3:0] r_sc1;
  logic [3:0] r_sc2;
  logic       w_press;
  logic       w_ok;
  logic       w_wait;
  logic [3:0] w_inc1;
  logic [3:0] w_inc2;

  key_press_edge u_key (
    .clk     (clk),
    .i_clr   (stateReset),
    .i_key   (userCont),
    .o_press (w_press)
  );

  assign w_ok   = is_animal(choice);
  assign w_inc1 = r_sc1 + 4'd1;
  assign w_inc2 = r_sc2 + 4'd1;
  assign w_wait = (r_state == P1_WAIT) ||
                  (r_state == P2_WAIT);

  always_ff @(posedge clk) begin
    if (stateReset) begin
      r_state <= P1_WAIT;
      r_p1    <= 3'b000;
      r_p2    <= 3'b000;
      r_scen  <= 9'b0;
      r_w1    <= 1'b0;
      r_w2    <= 1'b0;
      r_sc1   <= 4'd0;
      r_sc2   <= 4'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        P1_WAIT:
          if (w_press && w_ok) r_p1 <= choice;
        P2_WAIT:
          if (w_press && w_ok) r_p2 <= choice;
        RESOLVE: begin
          r_scen <= scenario_bit(r_p1, r_p2);
          r_w1   <= beats(r_p1, r_p2);
          r_w2   <= beats(r_p2, r_p1);
        end
        SHOW:
          if (draw_done) r_scen <= 9'b0;
        SCORE: begin
          if (r_w1) r_sc1 <= w_inc1;
          if (r_w2) r_sc2 <= w_inc2;
        end
        OVER:
          if (w_press) begin
            r_sc1 <= 4'd0;
            r_sc2 <= 4'd0;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      P1_WAIT:
        if (w_press && w_ok) w_next = P2_WAIT;
      P2_WAIT:
        if (w_press && w_ok) w_next = RESOLVE;
      RESOLVE:
        w_next = SHOW;
      SHOW:
        if (draw_done) w_next = SCORE;
      SCORE:
        if ((r_w1 && w_inc1 == WIN) ||
            (r_w2 && w_inc2 == WIN))
          w_next = OVER;
        else
          w_next = P1_WAIT;
      OVER:
        if (w_press) w_next = P1_WAIT;
      default:
        w_next = P1_WAIT;
    endcase
  end

  always_comb begin
    phase = 2'b10;
    case (r_state)
      P1_WAIT: phase = 2'b00;
      P2_WAIT: phase = 2'b01;
      OVER:    phase = 2'b11;
      default: phase = 2'b10;
    endcase
  end

  assign scenario       = r_scen;
  assign scenario_valid = (r_state == SHOW);
  assign winner1        = (r_state == SCORE) & r_w1;
  assign winner2        = (r_state == SCORE) & r_w2;
  assign player1        = r_sc1;
  assign player2        = r_sc2;
  assign bad_choice     = w_press & ~w_ok & w_wait;

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge with WIN_SCORE = 2.
// Expected values are hand-derived from the round rules.
module tb_round_judge;

  logic       clk = 1'b0;
  logic       stateReset;
  logic [2:0] choice;
  logic       userCont;
  logic       draw_done;
  logic [8:0] scenario;
  logic       scenario_valid;
  logic       winner1;
  logic       winner2;
  logic [3:0] player1;
  logic [3:0] player2;
  logic [1:0] phase;
  logic       bad_choice;

  int errs   = 0;
  int checks = 0;
  int n_bad  = 0;
  int n_w1   = 0;
  int n_w2   = 0;

  always #5 clk = ~clk;

  round_judge #(.WIN_SCORE(2)) dut (
    .clk            (clk),
    .stateReset     (stateReset),
    .choice         (choice),
    .userCont       (userCont),
    .draw_done      (draw_done),
    .scenario       (scenario),
    .scenario_valid (scenario_valid),
    .winner1        (winner1),
    .winner2        (winner2),
    .player1        (player1),
    .player2        (player2),
    .phase          (phase),
    .bad_choice     (bad_choice)
  );

  always @(negedge clk) begin
    if (bad_choice) n_bad++;
    if (winner1)    n_w1++;
    if (winner2)    n_w2++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] c);
    choice   = c;
    userCont = 1'b1;
    cyc(6);
    userCont = 1'b0;
    cyc(4);
  endtask

  task automatic draw();
    draw_done = 1'b1;
    cyc(1);
    draw_done = 1'b0;
  endtask

  initial begin
    stateReset = 1'b1;
    choice     = 3'b000;
    userCont   = 1'b0;
    draw_done  = 1'b0;
    cyc(3);
    stateReset = 1'b0;
    cyc(1);
    chk("rst_scen",  scenario, 9'b0);
    chk("rst_valid", scenario_valid, 1'b0);
    chk("rst_phase", phase, 2'b00);
    chk("rst_p1",    player1, 4'd0);
    chk("rst_p2",    player2, 4'd0);
    chk("rst_w",     {winner1, winner2, bad_choice}, 3'b0);

    // invalid choice is rejected, then dog latches as p1
    press(3'b011);
    chk("bad_cnt",   n_bad, 1);
    chk("bad_phase", phase, 2'b00);
    press(3'b010);
    chk("p1_phase",  phase, 2'b01);

    // p2 cat: RESOLVE 4 negedges after key, SHOW one later
    choice   = 3'b001;
    userCont = 1'b1;
    cyc(4);
    chk("res_phase", phase, 2'b10);
    chk("res_valid", scenario_valid, 1'b0);
    cyc(1);
    chk("show_valid", scenario_valid, 1'b1);
    chk("show_scen",  scenario, 9'b000100000);
    userCont = 1'b0;
    cyc(10);
    chk("hold_scen",  scenario, 9'b000100000);
    chk("hold_valid", scenario_valid, 1'b1);
    draw();
    chk("sc_w1",    winner1, 1'b1);
    chk("sc_w2",    winner2, 1'b0);
    chk("sc_scen",  scenario, 9'b0);
    chk("sc_valid", scenario_valid, 1'b0);
    chk("sc_p1old", player1, 4'd0);
    cyc(1);
    chk("r1_p1",    player1, 4'd1);
    chk("r1_phase", phase, 2'b00);
    chk("r1_w1off", winner1, 1'b0);

    // long hold latches exactly one choice
    choice   = 3'b100;
    userCont = 1'b1;
    cyc(50);
    userCont = 1'b0;
    cyc(4);
    chk("hold50_phase", phase, 2'b01);
    press(3'b100);
    chk("tie_phase", phase, 2'b10);
    chk("tie_scen",  scenario, 9'b000000001);
    press(3'b001);
    chk("showpress_phase", phase, 2'b10);
    chk("showpress_scen",  scenario, 9'b000000001);
    chk("showpress_valid", scenario_valid, 1'b1);
    draw();
    chk("tie_w", {winner1, winner2}, 2'b00);
    cyc(1);
    chk("tie_p1",  player1, 4'd1);
    chk("tie_p2",  player2, 4'd0);
    chk("tie_ph2", phase, 2'b00);

    // reset on the same edge as draw_done
    press(3'b001);
    press(3'b010);
    chk("pre_rst_valid", scenario_valid, 1'b1);
    stateReset = 1'b1;
    draw_done  = 1'b1;
    cyc(1);
    stateReset = 1'b0;
    draw_done  = 1'b0;
    chk("mid_scen",  scenario, 9'b0);
    chk("mid_valid", scenario_valid, 1'b0);
    chk("mid_phase", phase, 2'b00);
    chk("mid_p1",    player1, 4'd0);
    chk("mid_w",     {winner1, winner2}, 2'b00);
    cyc(2);
    chk("mid_w2cnt", n_w2, 0);

    // key held through reset release is not a press
    choice     = 3'b001;
    userCont   = 1'b1;
    stateReset = 1'b1;
    cyc(2);
    stateReset = 1'b0;
    cyc(10);
    userCont = 1'b0;
    cyc(4);
    chk("heldrst_phase", phase, 2'b00);

    // two cat-vs-chicken rounds end the match
    press(3'b001);
    press(3'b100);
    chk("m1_scen", scenario, 9'b001000000);
    draw();
    chk("m1_w1", winner1, 1'b1);
    cyc(1);
    chk("m1_p1",    player1, 4'd1);
    chk("m1_phase", phase, 2'b00);
    press(3'b001);
    press(3'b100);
    draw();
    chk("m2_w1", winner1, 1'b1);
    cyc(1);
    chk("m2_p1",    player1, 4'd2);
    chk("m2_p2",    player2, 4'd0);
    chk("m2_phase", phase, 2'b11);
    draw();
    cyc(2);
    chk("over_dd_phase", phase, 2'b11);
    chk("over_dd_p1",    player1, 4'd2);
    chk("over_valid",    scenario_valid, 1'b0);
    press(3'b001);
    chk("clr_p1",    player1, 4'd0);
    chk("clr_p2",    player2, 4'd0);
    chk("clr_phase", phase, 2'b00);

    chk("tot_w1",  n_w1, 3);
    chk("tot_w2",  n_w2, 0);
    chk("tot_bad", n_bad, 1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
